ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizer, clock glitch filter, frame FSM and scan-code decoder.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity rejection of received frames.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 60000
) (
    input  logic        clk_sys,
    input  logic        Reset_I,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity over data plus parity bit holds when the total count of ones is odd.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic            clk_meta_r;
    logic            clk_sync_r;
    logic            data_meta_r;
    logic            data_sync_r;
    logic            filt_clk_r;
    logic [FW-1:0]   filt_cnt_r;
    logic            fall_r;
    logic            sample_r;

    state_t          state_r;
    state_t          state_s;
    logic [2:0]      bit_cnt_r;
    logic [2:0]      bit_cnt_s;
    logic [7:0]      shift_r;
    logic [7:0]      shift_s;
    logic [TW-1:0]   tout_r;
    logic [TW-1:0]   tout_s;
    logic            frame_err_r;
    logic            err_s;
    logic            byte_valid_r;
    logic            valid_s;
    logic            parity_bad_s;

    logic            ext_r;
    logic            ext_s;
    logic            rel_r;
    logic            rel_s;
    logic [10:0]     key_r;
    logic [10:0]     key_s;
    logic            emit_s;

`ifdef PS2_PARITY_CHECK_EN
    logic            parity_r;
    logic            parity_s;
`endif

    // Two-flop synchronizers for both PS/2 lines; idle bus level is high.
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock filter: accept a new level after FILTER_LEN consecutive disagreeing samples,
    // and capture the data line together with an accepted falling edge.
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= '0;
            fall_r     <= 1'b0;
            sample_r   <= 1'b0;
        end else begin
            fall_r <= 1'b0;
            if (clk_sync_r != filt_clk_r) begin
                if (filt_cnt_r == FILT_MAX) begin
                    filt_clk_r <= clk_sync_r;
                    filt_cnt_r <= '0;
                    fall_r     <= ~clk_sync_r;
                    sample_r   <= data_sync_r;
                end else begin
                    filt_cnt_r <= filt_cnt_r + FW'(1);
                end
            end else begin
                filt_cnt_r <= '0;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign parity_bad_s = ~odd_parity_ok(shift_r, parity_r);
`else
    assign parity_bad_s = 1'b0;
`endif

    // Frame FSM next-state logic, including the inactivity abort.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        err_s     = 1'b0;
        valid_s   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_s  = parity_r;
`endif
        if (state_r == ST_IDLE) begin
            tout_s = '0;
        end else if (fall_r) begin
            tout_s = '0;
        end else begin
            tout_s = tout_r + TW'(1);
        end

        case (state_r)
            ST_IDLE: begin
                if (fall_r) begin
                    if (!sample_r) begin
                        state_s   = ST_DATA;
                        bit_cnt_s = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_r) begin
                    shift_s = {sample_r, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_PARITY;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_r) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_s = sample_r;
`endif
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_r) begin
                    state_s   = ST_IDLE;
                    bit_cnt_s = 3'd0;
                    if (sample_r && !parity_bad_s) begin
                        valid_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = 3'd0;
            end
        endcase

        if ((state_r != ST_IDLE) && !fall_r && (tout_r == TOUT_MAX)) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 3'd0;
            tout_s    = '0;
            err_s     = 1'b1;
            valid_s   = 1'b0;
        end else begin
            valid_s = valid_s;
        end
    end

    // Frame FSM state register; byte_valid and frame_err are single-cycle pulses.
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            tout_r       <= '0;
            frame_err_r  <= 1'b0;
            byte_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            tout_r       <= tout_s;
            frame_err_r  <= err_s;
            byte_valid_r <= valid_s;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    // Received parity bit, checked when the stop bit arrives.
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_s;
        end
    end
`endif

    // Scan-code decoder: prefixes set flags, other bytes emit one key event.
    always_comb begin
        ext_s  = ext_r;
        rel_s  = rel_r;
        key_s  = key_r;
        emit_s = 1'b0;
        if (frame_err_r) begin
            ext_s = 1'b0;
            rel_s = 1'b0;
        end else if (byte_valid_r) begin
            case (shift_r)
                8'hE0: ext_s = 1'b1;
                8'hF0: rel_s = 1'b1;
                8'hE1: emit_s = 1'b0;
                8'hFA, 8'hAA, 8'hEE, 8'hFE: emit_s = ext_r | rel_r;
                default: emit_s = 1'b1;
            endcase
        end else begin
            emit_s = 1'b0;
        end

        if (emit_s) begin
            key_s = {~key_r[10], ~rel_r, ext_r, shift_r};
            ext_s = 1'b0;
            rel_s = 1'b0;
        end else begin
            key_s = key_r;
        end
    end

    // Decoder flags and the held key event word.
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            ext_r <= 1'b0;
            rel_r <= 1'b0;
            key_r <= 11'h000;
        end else begin
            ext_r <= ext_s;
            rel_r <= rel_s;
            key_r <= key_s;
        end
    end

    assign ps2_key   = key_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (honours PS2_PARITY_CHECK_EN if defined).
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 300;
    localparam int HALF       = 20;

    logic        clk_sys;
    logic        Reset_I;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    int checks;
    int failures;
    int err_count;
    int err_base;

    ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys  (clk_sys),
        .Reset_I  (Reset_I),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Count frame_err pulses away from the active edge.
    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) err_count = err_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par, input logic stop);
        return {stop, par, b, 1'b0};
    endfunction

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, odd_par(b), 1'b1), 11);
        repeat (2 * HALF) @(negedge clk_sys);
    endtask

    initial begin
        logic [10:0] fr;
        checks    = 0;
        failures  = 0;
        err_count = 0;
        Reset_I   = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        repeat (4) @(negedge clk_sys);
        check_eq("reset_key", {21'd0, ps2_key}, 32'h000);
        check_eq("reset_err", {31'd0, frame_err}, 32'd0);
        Reset_I = 1'b1;
        repeat (10) @(negedge clk_sys);

        // First frame 1C with exact output latency on the stop bit.
        fr = make_frame(8'h1C, 1'b0, 1'b1);
        send_bits(fr, 10);
        @(negedge clk_sys);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (11) @(posedge clk_sys);
        #1 check_eq("latency_before", {21'd0, ps2_key}, 32'h000);
        @(posedge clk_sys);
        #1 check_eq("latency_at", {21'd0, ps2_key}, 32'h61C);
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (2 * HALF) @(negedge clk_sys);
        check_eq("first_no_err", err_count, 32'd0);

        send_byte(8'hF0);
        check_eq("f0_hold", {21'd0, ps2_key}, 32'h61C);
        send_byte(8'h1C);
        check_eq("release_1c", {21'd0, ps2_key}, 32'h01C);

        send_byte(8'hE0);
        send_byte(8'hF0);
        check_eq("e0f0_hold", {21'd0, ps2_key}, 32'h01C);
        send_byte(8'h75);
        check_eq("e0f0_75", {21'd0, ps2_key}, 32'h575);

        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_eq("f0e0_75", {21'd0, ps2_key}, 32'h175);

        send_byte(8'hAA);
        check_eq("aa_suppressed", {21'd0, ps2_key}, 32'h175);
        send_byte(8'hE1);
        send_byte(8'h1C);
        check_eq("e1_ignored", {21'd0, ps2_key}, 32'h61C);
        check_eq("no_err_so_far", err_count, 32'd0);

        // Bad stop bit.
        err_base = err_count;
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
        repeat (2 * HALF) @(negedge clk_sys);
        check_eq("stop0_err", err_count - err_base, 32'd1);
        check_eq("stop0_key", {21'd0, ps2_key}, 32'h61C);

        // frame_err clears a pending release prefix.
        send_byte(8'hF0);
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
        repeat (2 * HALF) @(negedge clk_sys);
        send_byte(8'h1C);
        check_eq("err_clears_rel", {21'd0, ps2_key}, 32'h21C);

        // Timeout after four bits, then a normal frame.
        err_base = err_count;
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 4);
        repeat (TIMEOUT + 2 * HALF) @(negedge clk_sys);
        check_eq("timeout_err", err_count - err_base, 32'd1);
        send_byte(8'h29);
        check_eq("after_timeout", {21'd0, ps2_key}, 32'h629);

        // Start bit of 1 in IDLE.
        err_base = err_count;
        send_bits(11'h7FF, 1);
        repeat (2 * HALF) @(negedge clk_sys);
        check_eq("start1_err", err_count - err_base, 32'd1);
        check_eq("start1_key", {21'd0, ps2_key}, 32'h629);

        // Clock glitch just below the filter length.
        err_base = err_count;
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (2 * HALF) @(negedge clk_sys);
        check_eq("glitch_no_err", err_count - err_base, 32'd0);
        send_byte(8'h1C);
        check_eq("after_glitch", {21'd0, ps2_key}, 32'h21C);

        // Wrong parity bit.
        err_base = err_count;
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
        repeat (2 * HALF) @(negedge clk_sys);
`ifdef PS2_PARITY_CHECK_EN
        check_eq("parity_err", err_count - err_base, 32'd1);
        check_eq("parity_key", {21'd0, ps2_key}, 32'h21C);
`else
        check_eq("parity_err", err_count - err_base, 32'd0);
        check_eq("parity_key", {21'd0, ps2_key}, 32'h61C);
`endif

        // Reset mid-DATA.
        err_base = err_count;
        send_bits(make_frame(8'h75, 1'b0, 1'b1), 4);
        @(negedge clk_sys);
        Reset_I = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_eq("midreset_key", {21'd0, ps2_key}, 32'h000);
        Reset_I = 1'b1;
        repeat (TIMEOUT + 2 * HALF) @(negedge clk_sys);
        check_eq("midreset_no_err", err_count - err_base, 32'd0);
        send_byte(8'h75);
        check_eq("after_reset", {21'd0, ps2_key}, 32'h675);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
